// File: rtl/conv_inst_sequencer.sv
// conv_inst_sequencer
//   Generates the 34-bit core instruction stream for a full convolution run.
//   For every kernel index it walks through: array clear, weight SRAM -> L0,
//   kernel load, activation SRAM -> L0, execute, drain, and OFIFO readout
//   with writeback into psum memory.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-low reset
//   start        begin a run (only honoured while idle)
//   abort        synchronous return to idle from any state
//   ofifo_valid  core OFIFO holds data
//   inst         registered core instruction word
//   xw_mode      0 = activation path, 1 = weight path
//   core_reset   active-high clear to core/array
//   busy         run in progress
//   done         one-cycle pulse at the end of a completed run
//   kij_idx      current kernel index
//
// Instruction word layout
//   [33] acc  [32] CEN_pmem  [31] WEN_pmem  [30:20] A_pmem
//   [19] CEN_xmem  [18] WEN_xmem  [17:7] A_xmem
//   [6] ofifo_rd [5] ififo_wr [4] ififo_rd [3] l0_rd [2] l0_wr [1] execute [0] load

module conv_inst_sequencer #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_kij = 9,
    parameter int len_nij = 36,
    parameter int addr_w  = 11,
    parameter int w_base  = 1024,
    parameter int rst_cyc = 10,
    parameter int gap_cyc = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        xw_mode,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_idx
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CMAX  = max2(max2(max2(rst_cyc, gap_cyc), max2(col, len_nij)), row + col);
    localparam int CNT_W = $clog2(CMAX + 1);
    localparam int PW    = $clog2(len_nij + 1);

    localparam logic [33:0] IDLE_WORD = {1'b0, 1'b1, 1'b1, {addr_w{1'b0}},
                                         1'b1, 1'b1, {addr_w{1'b0}}, 7'd0};

    // Elaboration-time parameter sanity; addresses are never wrapped in logic.
    if (longint'(len_kij) * longint'(len_nij) > (longint'(1) << addr_w)) begin : g_chk_pmem
        $error("conv_inst_sequencer: len_kij*len_nij exceeds pmem address space");
    end
    if (longint'(w_base) + longint'(col) > (longint'(1) << addr_w)) begin : g_chk_xmem
        $error("conv_inst_sequencer: w_base+col exceeds xmem address space");
    end
    if (len_kij > 16) begin : g_chk_kij
        $error("conv_inst_sequencer: len_kij must not exceed 16");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_WLD, S_WDRN, S_KLOAD, S_GAP,
        S_XLD, S_XDRN, S_EXEC, S_DRAIN, S_OFRD, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    t_q, t_d;
    logic [3:0]          kij_q, kij_d;
    logic [PW-1:0]       popped_q, popped_d;
    logic                pend_q, pend_d;
    logic [addr_w-1:0]   paddr_q, paddr_d;

    logic [33:0]         inst_q, inst_d;
    logic                xw_mode_q, xw_mode_d;
    logic                core_reset_q, core_reset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [3:0]          kij_idx_q, kij_idx_d;

    // Instruction fields assembled into inst_d
    logic                cen_p, wen_p, cen_x, wen_x;
    logic [addr_w-1:0]   a_p, a_x;
    logic                ofifo_rd, l0_rd, l0_wr, exec_s, load_s;

    always_comb begin
        state_d      = state_q;
        t_d          = t_q + CNT_W'(1);
        kij_d        = kij_q;
        popped_d     = popped_q;
        pend_d       = 1'b0;
        paddr_d      = paddr_q;

        cen_p        = 1'b1;
        wen_p        = 1'b1;
        a_p          = '0;
        cen_x        = 1'b1;
        wen_x        = 1'b1;
        a_x          = '0;
        ofifo_rd     = 1'b0;
        l0_rd        = 1'b0;
        l0_wr        = 1'b0;
        exec_s       = 1'b0;
        load_s       = 1'b0;

        xw_mode_d    = 1'b0;
        core_reset_d = 1'b0;
        busy_d       = 1'b1;
        done_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                t_d    = '0;
                if (start) begin
                    state_d  = S_CLR;
                    kij_d    = '0;
                    paddr_d  = '0;
                    popped_d = '0;
                end
            end
            S_CLR: begin
                core_reset_d = 1'b1;
                if (t_q == CNT_W'(rst_cyc - 1)) begin
                    state_d = S_WLD;
                    t_d     = '0;
                end
            end
            S_WLD: begin
                // SRAM read data arrives one cycle after the address, so the
                // L0 write strobe trails the first read by a cycle.
                xw_mode_d = 1'b1;
                cen_x     = 1'b0;
                a_x       = addr_w'(w_base) + addr_w'(t_q);
                l0_wr     = (t_q != '0);
                if (t_q == CNT_W'(col - 1)) begin
                    state_d = S_WDRN;
                    t_d     = '0;
                end
            end
            S_WDRN: begin
                xw_mode_d = 1'b1;
                l0_wr     = 1'b1;
                state_d   = S_KLOAD;
                t_d       = '0;
            end
            S_KLOAD: begin
                l0_rd  = 1'b1;
                load_s = 1'b1;
                if (t_q == CNT_W'(col - 1)) begin
                    state_d = S_GAP;
                    t_d     = '0;
                end
            end
            S_GAP: begin
                if (t_q == CNT_W'(gap_cyc - 1)) begin
                    state_d = S_XLD;
                    t_d     = '0;
                end
            end
            S_XLD: begin
                cen_x = 1'b0;
                a_x   = addr_w'(t_q);
                l0_wr = (t_q != '0);
                if (t_q == CNT_W'(len_nij - 1)) begin
                    state_d = S_XDRN;
                    t_d     = '0;
                end
            end
            S_XDRN: begin
                l0_wr   = 1'b1;
                state_d = S_EXEC;
                t_d     = '0;
            end
            S_EXEC: begin
                exec_s = 1'b1;
                l0_rd  = 1'b1;
                if (t_q == CNT_W'(len_nij - 1)) begin
                    state_d = S_DRAIN;
                    t_d     = '0;
                end
            end
            S_DRAIN: begin
                if (t_q == CNT_W'(row + col - 1)) begin
                    state_d  = S_OFRD;
                    t_d      = '0;
                    popped_d = '0;
                end
            end
            S_OFRD: begin
                t_d = '0;
                if (ofifo_valid && (popped_q < PW'(len_nij))) begin
                    ofifo_rd = 1'b1;
                    popped_d = popped_q + PW'(1);
                    pend_d   = 1'b1;
                end
                // Every kij writes exactly len_nij words, so a running
                // counter equals kij*len_nij + pop ordinal.
                if (pend_q) begin
                    cen_p   = 1'b0;
                    wen_p   = 1'b0;
                    a_p     = paddr_q;
                    paddr_d = paddr_q + addr_w'(1);
                end
                if (pend_q && (popped_q == PW'(len_nij))) begin
                    if (kij_q == 4'(len_kij - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        kij_d   = kij_q + 4'd1;
                        state_d = S_CLR;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                t_d     = '0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                t_d     = '0;
                state_d = S_IDLE;
            end
        endcase

        inst_d    = {1'b0, cen_p, wen_p, a_p, cen_x, wen_x, a_x,
                     ofifo_rd, 2'b00, l0_rd, l0_wr, exec_s, load_s};
        kij_idx_d = kij_q;

        if (abort) begin
            state_d      = S_IDLE;
            t_d          = '0;
            kij_d        = '0;
            popped_d     = '0;
            pend_d       = 1'b0;
            inst_d       = IDLE_WORD;
            xw_mode_d    = 1'b0;
            core_reset_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            kij_idx_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            t_q          <= '0;
            kij_q        <= '0;
            popped_q     <= '0;
            pend_q       <= 1'b0;
            paddr_q      <= '0;
            inst_q       <= IDLE_WORD;
            xw_mode_q    <= 1'b0;
            core_reset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            kij_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            kij_q        <= kij_d;
            popped_q     <= popped_d;
            pend_q       <= pend_d;
            paddr_q      <= paddr_d;
            inst_q       <= inst_d;
            xw_mode_q    <= xw_mode_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            kij_idx_q    <= kij_idx_d;
        end
    end

    assign inst       = inst_q;
    assign xw_mode    = xw_mode_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign kij_idx    = kij_idx_q;

endmodule
